// File: rtl/xor_nor_tester.sv
// rtl/xor_nor_tester.sv - exhaustive 3-input stimulus/check sequencer for an XOR/NOR DUT
module xor_nor_tester #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       X_in,
    input  logic       Y_in,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] ErrCount,
    output logic       ErrFlag,
    output logic [2:0] FirstErr
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] abc_q, abc_d;
    logic [3:0] err_q, err_d;
    logic [2:0] first_q, first_d;

    logic exp_x;
    logic exp_y;
    logic mismatch;

    assign exp_x    = vec_q[2] ^ vec_q[1];
    assign exp_y    = ~(exp_x | vec_q[0]);
    // X and Y both wrong still counts as one failing vector
    assign mismatch = (X_in != exp_x) || (Y_in != exp_y);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
            cnt_q   <= 4'd0;
            abc_q   <= 3'd0;
            err_q   <= 4'd0;
            first_q <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        abc_d   = abc_q;
        err_d   = err_q;
        first_d = first_q;
        case (state_q)
            ST_IDLE: begin
                abc_d = 3'd0;
                if (Start) begin
                    state_d = ST_APPLY;
                    vec_d   = 3'd0;
                    err_d   = 4'd0;
                    first_d = 3'd0;
                end
            end
            ST_APPLY: begin
                abc_d   = vec_q;
                cnt_d   = 4'(SETTLE_CYCLES);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 4'd1;
                    if (err_q == 4'd0) begin
                        first_d = vec_q;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: begin
                if (Start) begin
                    state_d = ST_APPLY;
                    vec_d   = 3'd0;
                    err_d   = 4'd0;
                    first_d = 3'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign A        = abc_q[2];
    assign B        = abc_q[1];
    assign C        = abc_q[0];
    assign Busy     = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign Done     = (state_q == ST_DONE);
    assign ErrCount = err_q;
    assign ErrFlag  = (err_q != 4'd0);
    assign FirstErr = first_q;

endmodule

// File: tb/tb_xor_nor_tester.sv
// tb/tb_xor_nor_tester.sv - table-driven check of xor_nor_tester against fault-injecting DUT models
module tb_xor_nor_tester;

    logic       clk;
    logic       rst;
    logic       start;
    logic       x_in, y_in;
    logic       a, b, c, busy, done, err_flag;
    logic [3:0] err_count;
    logic [2:0] first_err;

    logic       start1;
    logic       x1, y1;
    logic       a1, b1, c1, busy1, done1, flag1;
    logic [3:0] err1;
    logic [2:0] first1;

    int mode;
    int tests;
    int fails;
    int first_done, first_errc, first_busy;

    // DUT models: 0 correct, 1 Y stuck 0, 2 X stuck 0, 3 both outputs inverted
    assign x_in = (mode == 2) ? 1'b0 : (mode == 3) ? ~(a ^ b) : (a ^ b);
    assign y_in = (mode == 1) ? 1'b0 : (mode == 3) ? ((a ^ b) | c) : ~((a ^ b) | c);
    assign x1   = a1 ^ b1;
    assign y1   = ~((a1 ^ b1) | c1);

    xor_nor_tester #(.SETTLE_CYCLES(4)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .X_in(x_in), .Y_in(y_in),
        .A(a), .B(b), .C(c), .Busy(busy), .Done(done),
        .ErrCount(err_count), .ErrFlag(err_flag), .FirstErr(first_err)
    );

    xor_nor_tester #(.SETTLE_CYCLES(1)) dut1 (
        .Clk(clk), .Rst(rst), .Start(start1), .X_in(x1), .Y_in(y1),
        .A(a1), .B(b1), .C(c1), .Busy(busy1), .Done(done1),
        .ErrCount(err1), .ErrFlag(flag1), .FirstErr(first1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse Start, then count Busy cycles; optionally poke Rst or Start at busy cycle poke_at
    task automatic run(input int poke_at, input bit poke_rst, output int n);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        first_done = int'(done);
        first_errc = int'(err_count);
        first_busy = int'(busy);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == poke_at) begin
                if (poke_rst) rst = 1'b1;
                else start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    typedef struct {
        int mode;
        int exp_cnt;
        int exp_first;
        int exp_flag;
    } vec_t;

    vec_t tbl[5];
    int   n;

    initial begin
        tests = 0;
        fails = 0;
        mode = 0;
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;

        tbl[0] = '{mode: 0, exp_cnt: 0, exp_first: 0, exp_flag: 0};
        tbl[1] = '{mode: 1, exp_cnt: 2, exp_first: 0, exp_flag: 1};
        tbl[2] = '{mode: 2, exp_cnt: 4, exp_first: 2, exp_flag: 1};
        tbl[3] = '{mode: 3, exp_cnt: 8, exp_first: 0, exp_flag: 1};
        tbl[4] = '{mode: 0, exp_cnt: 0, exp_first: 0, exp_flag: 0};

        repeat (3) @(negedge clk);
        chk("reset_abc", int'({a, b, c}), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_errcount", int'(err_count), 0);
        chk("reset_errflag", int'(err_flag), 0);
        chk("reset_firsterr", int'(first_err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_start_busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            run(0, 1'b0, n);
            chk($sformatf("t%0d_first_busy", i), first_busy, 1);
            chk($sformatf("t%0d_first_done_low", i), first_done, 0);
            chk($sformatf("t%0d_first_errcount_clr", i), first_errc, 0);
            chk($sformatf("t%0d_busy_len", i), n, 48);
            chk($sformatf("t%0d_done", i), int'(done), 1);
            chk($sformatf("t%0d_errcount", i), int'(err_count), tbl[i].exp_cnt);
            chk($sformatf("t%0d_errflag", i), int'(err_flag), tbl[i].exp_flag);
            if (tbl[i].exp_flag != 0)
                chk($sformatf("t%0d_firsterr", i), int'(first_err), tbl[i].exp_first);
            chk($sformatf("t%0d_abc_hold", i), int'({a, b, c}), 7);
        end

        mode = 0;
        repeat (3) @(negedge clk);
        chk("done_held", int'(done), 1);

        // Start while busy must not disturb the run
        run(10, 1'b0, n);
        chk("busy_start_len", n, 48);
        chk("busy_start_done", int'(done), 1);
        chk("busy_start_err", int'(err_count), 0);

        // Reset during SETTLE of vector 3 (busy cycle 21)
        mode = 1;
        run(21, 1'b1, n);
        chk("rst_mid_len", n, 21);
        chk("rst_mid_abc", int'({a, b, c}), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_errcount", int'(err_count), 0);
        chk("rst_mid_firsterr", int'(first_err), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_stays_idle", int'(busy), 0);
        chk("rst_mid_no_done", int'(done), 0);
        mode = 0;
        run(0, 1'b0, n);
        chk("rst_rerun_len", n, 48);
        chk("rst_rerun_err", int'(err_count), 0);

        // Rst wins over Start in the same cycle
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_prio_busy", int'(busy), 0);
        chk("rst_prio_done", int'(done), 0);
        @(negedge clk);
        chk("rst_prio_idle", int'(busy), 0);

        // SETTLE_CYCLES=1 instance
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("s1_busy_len", n, 24);
        chk("s1_done", int'(done1), 1);
        chk("s1_errcount", int'(err1), 0);
        chk("s1_errflag", int'(flag1), 0);
        chk("s1_abc_hold", int'({a1, b1, c1}), 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
